// File: rtl/tia_pkg.sv
// Shared constants and encodings for the TIA color-clock / CPU sync logic.
package tia_pkg;

  // Default line geometry (NTSC TIA).
  localparam int LINE_CLOCKS_DEF   = 228;
  localparam int HBLANK_CLOCKS_DEF = 68;
  localparam int HCOUNT_WIDTH_DEF  = 8;

  // WSYNC controller states: RUN lets the CPU go, HALT holds RDY low.
  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } sync_state_e;

  // Divide-by-three CPU phase encoding.
  localparam logic [1:0] PHASE_PHI0   = 2'd0;  // phi0 high
  localparam logic [1:0] PHASE_MID    = 2'd1;
  localparam logic [1:0] PHASE_CPU_EN = 2'd2;  // last color clock of a CPU cycle

  // Next phase in the 0 -> 1 -> 2 -> 0 sequence; 3 falls back to 0.
  function automatic logic [1:0] phase_next(input logic [1:0] p);
    logic [1:0] n;
    case (p)
      PHASE_PHI0: n = PHASE_MID;
      PHASE_MID:  n = PHASE_CPU_EN;
      default:    n = PHASE_PHI0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/tia_hcount_counter.sv
// Horizontal color-clock counter: wraps every LINE_CLOCKS, cleared by RSYNC,
// produces a registered line_start pulse and the decoded hblank window.
module tia_hcount_counter
  import tia_pkg::*;
#(
  parameter int LINE_CLOCKS   = LINE_CLOCKS_DEF,
  parameter int HBLANK_CLOCKS = HBLANK_CLOCKS_DEF,
  parameter int HCOUNT_WIDTH  = HCOUNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    resphi0_n,
  input  logic                    rsync_strobe,
  output logic [HCOUNT_WIDTH-1:0] hcount,
  output logic                    hblank,
  output logic                    line_start,
  output logic                    at_last
);

  localparam logic [HCOUNT_WIDTH-1:0] HCOUNT_LAST = HCOUNT_WIDTH'(LINE_CLOCKS - 1);
  localparam logic [HCOUNT_WIDTH-1:0] HBLANK_END  = HCOUNT_WIDTH'(HBLANK_CLOCKS);

  logic [HCOUNT_WIDTH-1:0] hcount_q, hcount_d;
  logic                    line_start_q, line_start_d;

  // Last clock of the line: the next edge is a natural wrap unless RSYNC wins.
  assign at_last = (hcount_q == HCOUNT_LAST);

  // Next-state: RSYNC clear overrides both increment and wrap.
  always_comb begin
    hcount_d     = hcount_q + HCOUNT_WIDTH'(1);
    line_start_d = 1'b0;
    if (rsync_strobe || at_last) begin
      hcount_d     = '0;
      line_start_d = 1'b1;
    end
  end

  // Counter and line_start registers.
  always_ff @(posedge clk or negedge resphi0_n) begin
    if (!resphi0_n) begin
      hcount_q     <= '0;
      line_start_q <= 1'b0;
    end else begin
      hcount_q     <= hcount_d;
      line_start_q <= line_start_d;
    end
  end

  assign hcount     = hcount_q;
  assign line_start = line_start_q;
  assign hblank     = (hcount_q < HBLANK_END);

endmodule

// File: rtl/tia_wsync_controller.sv
// CPU-side sequencer on the color clock: divide-by-three phase (phi0/cpu_en),
// horizontal counter, and the WSYNC/RSYNC halt of the 6502 RDY line.
module tia_wsync_controller
  import tia_pkg::*;
#(
  parameter int LINE_CLOCKS   = LINE_CLOCKS_DEF,
  parameter int HBLANK_CLOCKS = HBLANK_CLOCKS_DEF,
  parameter int HCOUNT_WIDTH  = HCOUNT_WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    resphi0_n,
  input  logic                    wsync_strobe,
  input  logic                    rsync_strobe,
  output logic [HCOUNT_WIDTH-1:0] hcount,
  output logic                    hblank,
  output logic                    line_start,
  output logic                    cpu_en,
  output logic                    phi0,
  output logic                    rdy
);

  logic [1:0]  phase_q, phase_d;
  sync_state_e state_q, state_d;
  logic        at_last;

  tia_hcount_counter #(
    .LINE_CLOCKS  (LINE_CLOCKS),
    .HBLANK_CLOCKS(HBLANK_CLOCKS),
    .HCOUNT_WIDTH (HCOUNT_WIDTH)
  ) u_hcount (
    .clk         (clk),
    .resphi0_n   (resphi0_n),
    .rsync_strobe(rsync_strobe),
    .hcount      (hcount),
    .hblank      (hblank),
    .line_start  (line_start),
    .at_last     (at_last)
  );

  // Free-running phase; neither strobe touches it.
  always_comb begin
    phase_d = phase_next(phase_q);
  end

  // WSYNC FSM next state. In RUN a wrap is not a release, so a WSYNC on the
  // last clock of a line holds for the whole following line.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (wsync_strobe) state_d = ST_HALT;
      ST_HALT: if (at_last || rsync_strobe) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // Phase and FSM state registers.
  always_ff @(posedge clk or negedge resphi0_n) begin
    if (!resphi0_n) begin
      phase_q <= PHASE_PHI0;
      state_q <= ST_RUN;
    end else begin
      phase_q <= phase_d;
      state_q <= state_d;
    end
  end

  assign phi0   = (phase_q == PHASE_PHI0);
  assign cpu_en = (phase_q == PHASE_CPU_EN);
  assign rdy    = (state_q == ST_RUN);

endmodule
